// File: rtl/button_debounce_repeat.sv
// button_debounce_repeat
//   Turns one raw board push-button into clean single-cycle event pulses:
//   two-flop synchroniser, press/release debounce, and auto-repeat while held.
//   button_flag feeds the load/calculate strobe of the notation converter.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release (>=1)
//   HOLD_CYCLES      held cycles after press acceptance before the first repeat (>=1)
//   REPEAT_CYCLES    cycles between repeat pulses; 0 disables auto-repeat
//   ACTIVE_LOW       1: button_signal==0 means pressed
//
// Ports
//   clock          in   system clock
//   reset          in   synchronous, active-low
//   button_signal  in   raw asynchronous button input
//   button_flag    out  1-cycle pulse on accepted press and on each auto-repeat
//   button_level   out  debounced pressed level
//   release_flag   out  1-cycle pulse on accepted release
//   repeat_active  out  high in REPEAT, or in DB_RELEASE entered from REPEAT
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | released, waiting for the synchronised input to read pressed
// DB_PRESS   | counting stable pressed cycles
// HELD       | press accepted, counting towards the first repeat
// REPEAT     | auto-repeating every REPEAT_CYCLES
// DB_RELEASE | counting stable released cycles; hold/repeat counters frozen

module button_debounce_repeat #(
   parameter int DEBOUNCE_CYCLES = 50_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 5_000_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic button_signal,
   output logic button_flag,
   output logic button_level,
   output logic release_flag,
   output logic repeat_active
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int RW = $clog2(REPEAT_CYCLES) + 1;

   localparam logic [CW-1:0] DB_TC     = CW'(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] HOLD_TC   = HW'(HOLD_CYCLES);
   localparam logic [RW-1:0] REP_TC    = RW'(REPEAT_CYCLES);
   localparam bit            REPEAT_EN = (REPEAT_CYCLES != 0);
   localparam logic          RELEASED  = ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      HELD,
      REPEAT,
      DB_RELEASE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [HW-1:0] hcnt, hcnt_n, hcnt_inc;
   logic [RW-1:0] rcnt, rcnt_n, rcnt_inc;
   logic          from_repeat, from_repeat_n;
   logic          press_pulse, release_pulse;
   logic          hold_step, repeat_step;

   logic sync_a, sync_b;
   logic pressed;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_a <= RELEASED;
         sync_b <= RELEASED;
      end else begin
         sync_a <= button_signal;
         sync_b <= sync_a;
      end
   end

   assign pressed  = ACTIVE_LOW ? ~sync_b : sync_b;
   assign hcnt_inc = hcnt + 1'b1;
   assign rcnt_inc = rcnt + 1'b1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         hcnt          <= '0;
         rcnt          <= '0;
         from_repeat   <= 1'b0;
         button_flag   <= 1'b0;
         release_flag  <= 1'b0;
         button_level  <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         hcnt          <= hcnt_n;
         rcnt          <= rcnt_n;
         from_repeat   <= from_repeat_n;
         button_flag   <= press_pulse;
         release_flag  <= release_pulse;
         button_level  <= (state_n == HELD) || (state_n == REPEAT) || (state_n == DB_RELEASE);
         repeat_active <= (state_n == REPEAT) || ((state_n == DB_RELEASE) && from_repeat_n);
      end
   end

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      hcnt_n        = hcnt;
      rcnt_n        = rcnt;
      from_repeat_n = from_repeat;
      press_pulse   = 1'b0;
      release_pulse = 1'b0;
      hold_step     = 1'b0;
      repeat_step   = 1'b0;

      case (state)
         IDLE: begin
            cnt_n  = '0;
            hcnt_n = '0;
            rcnt_n = '0;
            if (pressed) begin
               state_n = DB_PRESS;
               cnt_n   = CW'(1);
            end
         end
         DB_PRESS: begin
            if (!pressed) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == DB_TC) begin
               state_n     = HELD;
               cnt_n       = '0;
               hcnt_n      = '0;
               press_pulse = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_n       = DB_RELEASE;
               cnt_n         = CW'(1);
               from_repeat_n = 1'b0;
            end else begin
               hold_step = 1'b1;
            end
         end
         REPEAT: begin
            if (!pressed) begin
               state_n       = DB_RELEASE;
               cnt_n         = CW'(1);
               from_repeat_n = 1'b1;
            end else begin
               repeat_step = 1'b1;
            end
         end
         DB_RELEASE: begin
            if (pressed) begin
               // The cycle that leaves HELD/REPEAT is not counted, the cycle
               // that returns is, so a glitch delays the next repeat by
               // exactly the cycles spent here.
               cnt_n = '0;
               if (from_repeat) repeat_step = 1'b1;
               else             hold_step   = 1'b1;
            end else if (cnt == DB_TC) begin
               state_n       = IDLE;
               cnt_n         = '0;
               release_pulse = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            hcnt_n  = '0;
            rcnt_n  = '0;
         end
      endcase

      if (hold_step) begin
         state_n = HELD;
         if (REPEAT_EN && (hcnt_inc == HOLD_TC)) begin
            state_n     = REPEAT;
            rcnt_n      = '0;
            press_pulse = 1'b1;
         end else if (hcnt != HOLD_TC) begin
            // saturates at HOLD_CYCLES when auto-repeat is disabled
            hcnt_n = hcnt_inc;
         end
      end

      if (repeat_step) begin
         state_n = REPEAT;
         if (rcnt_inc == REP_TC) begin
            rcnt_n      = '0;
            press_pulse = 1'b1;
         end else begin
            rcnt_n = rcnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// tb_button_debounce_repeat
//   Directed bench for button_debounce_repeat with DEBOUNCE=4, HOLD=10,
//   REPEAT=3, active-low button. A second instance with REPEAT=0 covers the
//   no-auto-repeat case. Cycle n is the period following rising edge n; raw
//   input for edge n is driven on the preceding falling edge.

module tb_button_debounce_repeat;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic button_signal = 1'b1;

   logic button_flag, button_level, release_flag, repeat_active;
   logic nr_flag, nr_level, nr_release, nr_repeat;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   button_debounce_repeat #(
      .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
   ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .button_signal (button_signal),
      .button_flag   (button_flag),
      .button_level  (button_level),
      .release_flag  (release_flag),
      .repeat_active (repeat_active)
   );

   button_debounce_repeat #(
      .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
   ) u_norep (
      .clock         (clock),
      .reset         (reset),
      .button_signal (button_signal),
      .button_flag   (nr_flag),
      .button_level  (nr_level),
      .release_flag  (nr_release),
      .repeat_active (nr_repeat)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   // raw button level (1 = released) sampled at edge n
   function automatic logic raw_val(int t, int n);
      case (t)
         1: return (n >= 12);
         2: return !((n <= 2) || (n >= 4 && n <= 6));
         3: return (n >= 30);
         4: return (n == 20 || n == 21);
         default: return 1'b0;
      endcase
   endfunction

   // expected {button_flag, button_level, release_flag, repeat_active} in cycle n
   function automatic logic [3:0] exp_vec(int t, int n);
      logic f, l, r, a;
      f = 1'b0; l = 1'b0; r = 1'b0; a = 1'b0;
      case (t)
         1: begin
            f = (n == 6);
            l = (n >= 6 && n <= 17);
            r = (n == 18);
         end
         3: begin
            f = n inside {6, 16, 19, 22, 25, 28, 31};
            l = (n >= 6 && n <= 35);
            a = (n >= 16 && n <= 35);
            r = (n == 36);
         end
         4: begin
            f = n inside {6, 16, 19, 24, 27};
            l = (n >= 6);
            a = (n >= 16);
         end
         5: begin
            // reset sampled at edge 19; synchroniser restarts from released,
            // so the still-held button is a fresh press seen from edge 20
            f = n inside {6, 16, 26};
            l = (n >= 6 && n <= 18) || (n >= 26);
            a = (n >= 16 && n <= 18);
         end
         6: begin
            f = (n == 6);
            l = (n >= 6);
         end
         default: ;
      endcase
      return {f, l, r, a};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      button_signal = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic run_test(input int t, input int cycles);
      int flags;
      flags = 0;
      for (int n = 0; n < cycles; n++) begin
         button_signal = raw_val(t, n);
         reset = (t == 5 && n == 19) ? 1'b0 : 1'b1;
         @(posedge clock);
         #1;
         if (t == 6) begin
            check($sformatf("t6_cyc%0d", n), {28'd0, nr_flag, nr_level, nr_release, nr_repeat},
                  {28'd0, exp_vec(t, n)});
            if (nr_flag) flags++;
         end else begin
            check($sformatf("t%0d_cyc%0d", t, n),
                  {28'd0, button_flag, button_level, release_flag, repeat_active},
                  {28'd0, exp_vec(t, n)});
         end
         @(negedge clock);
      end
      if (t == 6) check("t6_flag_count", flags, 1);
   endtask

   initial begin
      do_reset();
      #1;
      check("reset_outputs", {28'd0, button_flag, button_level, release_flag, repeat_active}, 32'd0);
      check("reset_outputs_norep", {28'd0, nr_flag, nr_level, nr_release, nr_repeat}, 32'd0);
      @(negedge clock);

      run_test(1, 23);
      do_reset();
      run_test(2, 16);
      do_reset();
      run_test(3, 41);
      do_reset();
      run_test(4, 30);
      do_reset();
      run_test(5, 31);
      do_reset();
      run_test(6, 40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
